// File: rtl/data_mem_ws.sv
// Word memory with byte-lane stores and a fixed WAIT_CYCLES wait-state delay per access.
// rsp_valid rises WAIT_CYCLES edges after the handshake; one access in flight, held until rsp_ready.
module data_mem_ws #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [31:0]             req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_be,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int OFS    = $clog2(NBYTES);
   localparam int AW     = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef struct packed {
      logic                  we;
      logic [31:0]           addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [NBYTES-1:0]     be;
   } req_t;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   req_t                  req_q, req_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   req_t                  req_in;
   req_t                  op;
   logic                  hs;
   logic                  exec;
   logic                  mem_we;
   logic [31:0]           op_idx;
   logic                  op_err;
   logic [AW-1:0]         op_widx;

   assign req_ready = reset && (state_q == ST_IDLE);
   assign hs        = req_valid && req_ready;
   assign req_in    = {req_we, req_addr, req_wdata, req_be};

   // With zero wait states the access executes on the handshake edge, straight from the inputs.
   assign op      = (state_q == ST_IDLE) ? req_in : req_q;
   assign op_idx  = op.addr >> OFS;
   assign op_err  = (op_idx >= 32'(DEPTH));
   assign op_widx = op_idx[AW-1:0];
   assign mem_we  = exec && reset && op.we && !op_err;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      exec        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               req_d = req_in;
               if (WAIT_CYCLES == 0) begin
                  exec = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               exec = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (exec) begin
         state_d     = ST_RESP;
         rsp_valid_d = 1'b1;
         rsp_err_d   = op_err;
         rsp_rdata_d = (op.we || op_err) ? '0 : mem[op_widx];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (op.be[i]) begin
               mem[op_widx][i*8 +: 8] <= op.wdata[i*8 +: 8];
            end
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
